// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack: per-cycle operation encoding and default geometry.
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  localparam int unsigned LIFO_DEF_WIDTH = 12;
  localparam int unsigned LIFO_DEF_DEPTH = 5;

  function automatic op_e decode_op(input logic push, input logic pop);
    unique case ({pop, push})
      2'b01:   decode_op = OP_PUSH;
      2'b10:   decode_op = OP_POP;
      2'b11:   decode_op = OP_REPLACE;
      default: decode_op = OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lifo_regfile.sv
// DEPTH x WIDTH storage for the LIFO: one synchronous write port, one async read port,
// synchronous reset of every entry to zero.
module lifo_regfile
  import lifo_pkg::*;
#(
  parameter int unsigned WIDTH = LIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = LIFO_DEF_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with count/empty/full and optional sticky ovf/unf flags.
// Define LIFO_ERR_FLAGS_EN to enable the sticky error logic; otherwise ovf/unf read 0.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int unsigned WIDTH = LIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = LIFO_DEF_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned AW = $clog2(DEPTH);

  op_e              op;
  logic [CW-1:0]    count_nxt;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             ovf_evt;
  logic             unf_evt;

  assign op    = decode_op(push, pop);
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    count_nxt = count;
    we        = 1'b0;
    waddr     = '0;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    if (!clear) begin
      unique case (op)
        OP_PUSH: begin
          if (full) begin
            ovf_evt = 1'b1;
          end else begin
            we        = 1'b1;
            waddr     = AW'(count);
            count_nxt = count + CW'(1);
          end
        end
        OP_POP: begin
          if (empty) begin
            unf_evt = 1'b1;
          end else begin
            count_nxt = count - CW'(1);
          end
        end
        OP_REPLACE: begin
          // On an empty stack a replace degenerates to a push into entry 0.
          we = 1'b1;
          if (empty) begin
            waddr     = '0;
            count_nxt = CW'(1);
          end else begin
            waddr = AW'(count - CW'(1));
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= clear ? '0 : count_nxt;
    end
  end

  lifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Keep the read index in range while empty; the output is masked anyway.
  assign raddr = empty ? '0 : AW'(count - CW'(1));
  assign top   = empty ? '0 : rdata;

`ifdef LIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_evt)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (unf_evt)      unf <= 1'b1;
      else if (err_clr) unf <= 1'b0;
    end
  end
`else
  logic unused_err;
  assign unused_err = ^{err_clr, ovf_evt, unf_evt};
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed, table-driven bench for lifo_stack (WIDTH=12, DEPTH=5); flag expectations
// follow whether LIFO_ERR_FLAGS_EN is defined.
module tb_lifo_stack;

  localparam int unsigned W = 12;
  localparam int unsigned D = 5;
`ifdef LIFO_ERR_FLAGS_EN
  localparam bit EF = 1'b1;
`else
  localparam bit EF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, clear, push, pop, err_clr;
  logic [W-1:0] din;
  logic [W-1:0] top;
  logic [2:0]   count;
  logic         empty, full, ovf, unf;

  lifo_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .din(din),
    .err_clr(err_clr), .top(top), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, clear, push, pop, err_clr;
    logic [W-1:0] din;
    logic [2:0]   cnt;
    logic [W-1:0] top;
    logic         ov, un;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(input logic r, input logic c, input logic pu, input logic po,
                              input logic ec, input logic [W-1:0] d, input logic [2:0] n,
                              input logic [W-1:0] t, input logic o, input logic u);
    vec_t v;
    v.rst = r; v.clear = c; v.push = pu; v.pop = po; v.err_clr = ec; v.din = d;
    v.cnt = n; v.top = t; v.ov = o; v.un = u;
    return v;
  endfunction

  task automatic step(input string name, input vec_t v);
    logic [18:0] got, exp;
    @(negedge clk);
    rst = v.rst; clear = v.clear; push = v.push; pop = v.pop; err_clr = v.err_clr; din = v.din;
    @(posedge clk);
    #1;
    got = {count, top, empty, full, ovf, unf};
    exp = {v.cnt, v.top, (v.cnt == 3'd0), (v.cnt == 3'(D)), v.ov & EF, v.un & EF};
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got cnt=%0d top=%h e=%b f=%b ovf=%b unf=%b, expected cnt=%0d top=%h e=%b f=%b ovf=%b unf=%b",
                  name, count, top, empty, full, ovf, unf,
                  v.cnt, v.top, (v.cnt == 3'd0), (v.cnt == 3'(D)), v.ov & EF, v.un & EF);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = '0;

    //               rst clr psh pop ec  din      cnt top      ov un
    vecs.push_back(mk(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0)); // reset
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 12'(i), 3'(i), 12'(i), 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 12'h0AA, 5, 12'h005, 1, 0)); // push on full
    vecs.push_back(mk(0, 0, 0, 0, 0, 12'h000, 5, 12'h005, 1, 0)); // sticky
    vecs.push_back(mk(0, 0, 0, 0, 1, 12'h000, 5, 12'h005, 0, 0)); // err_clr
    vecs.push_back(mk(0, 0, 1, 0, 1, 12'h0BB, 5, 12'h005, 1, 0)); // error wins over clr
    vecs.push_back(mk(0, 0, 0, 0, 1, 12'h000, 5, 12'h005, 0, 0));
    for (int i = 4; i >= 1; i--)
      vecs.push_back(mk(0, 0, 0, 1, 0, 12'h000, 3'(i), 12'(i), 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 0)); // last pop
    vecs.push_back(mk(0, 0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 1)); // pop on empty
    vecs.push_back(mk(0, 0, 1, 1, 0, 12'h123, 1, 12'h123, 0, 1)); // replace on empty
    vecs.push_back(mk(0, 1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1)); // clear keeps flags
    vecs.push_back(mk(0, 0, 0, 1, 1, 12'h000, 0, 12'h000, 0, 1)); // unf wins over clr
    vecs.push_back(mk(0, 0, 0, 0, 1, 12'h000, 0, 12'h000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 12'h200, 1, 12'h200, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 12'h300, 2, 12'h300, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 12'h301, 3, 12'h301, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 12'hFFF, 3, 12'hFFF, 0, 0)); // replace
    vecs.push_back(mk(0, 0, 0, 1, 0, 12'h000, 2, 12'h300, 0, 0)); // entry below intact
    vecs.push_back(mk(0, 0, 1, 0, 0, 12'h400, 3, 12'h400, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 12'h500, 4, 12'h500, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 12'h600, 0, 12'h000, 0, 0)); // clear beats push
    vecs.push_back(mk(0, 0, 1, 0, 0, 12'h700, 1, 12'h700, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 12'h111, 2, 12'h111, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 12'h000, 1, 12'h700, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 12'h222, 0, 12'h000, 0, 0)); // rst mid-push
    vecs.push_back(mk(0, 0, 1, 0, 0, 12'h0AB, 1, 12'h0AB, 0, 0)); // lands in entry 0

    for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

    // Replace while full, then overflow, then reset clearing a set flag.
    step("seq_rst", mk(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0));
    for (int i = 0; i < 5; i++)
      step($sformatf("seq_fill%0d", i), mk(0, 0, 1, 0, 0, 12'hA00 + 12'(i), 3'(i + 1), 12'hA00 + 12'(i), 0, 0));
    step("seq_repl_full", mk(0, 0, 1, 1, 0, 12'hABC, 5, 12'hABC, 0, 0));
    step("seq_pop_after_repl", mk(0, 0, 0, 1, 0, 12'h000, 4, 12'hA03, 0, 0));
    step("seq_refill", mk(0, 0, 1, 0, 0, 12'h0DD, 5, 12'h0DD, 0, 0));
    step("seq_ovf", mk(0, 0, 1, 0, 0, 12'h0EE, 5, 12'h0DD, 1, 0));
    step("seq_rst_flags", mk(1, 1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 0));
    step("seq_pop_unf", mk(0, 0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 1));
    step("seq_push_after", mk(0, 0, 1, 0, 0, 12'h05A, 1, 12'h05A, 0, 1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
- REQ-001: Parameter WIDTH, default 12, data word width in bits (legal range 1-32).
- REQ-002: Parameter DEPTH, default 5, number of entries (legal range 2-64).
- REQ-003: Localparam CW = $clog2(DEPTH+1), width of the count output.
- REQ-004: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-005: rst  input  1  synchronous, active-high reset.
- REQ-006: clear  input  1  synchronous flush of stack pointer.
- REQ-007: push  input  1  write din onto the stack this cycle.
- REQ-008: pop  input  1  remove the top entry this cycle.
- REQ-009: din  input  WIDTH  push data.
- REQ-010: top  output  WIDTH  current top-of-stack value, combinational from state.
- REQ-011: count  output  CW  number of valid entries.
- REQ-012: empty, full  output  1 each  count==0, count==DEPTH.
- REQ-013: ovf, unf  output  1 each  sticky overflow/underflow error flags.
- REQ-014: err_clr  input  1  clears ovf/unf.

Function
- REQ-015: Operation per cycle SHALL be decoded as IDLE, PUSH, POP or REPLACE (push&pop).
- REQ-016: PUSH, not full: mem[count] <= din, count+1; top = din from the next cycle.
- REQ-017: PUSH when full (pop low): ignored, contents and count unchanged, ovf set.
- REQ-018: POP, not empty: count-1; popped entry value retained in storage.
- REQ-019: POP when empty (push low): ignored, count stays 0, unf set.
- REQ-020: REPLACE, not empty (including full): mem[count-1] <= din, count unchanged, no error.
- REQ-021: REPLACE when empty: treated as PUSH, count becomes 1, no underflow.
- REQ-022: clear SHALL set count to 0 and override push/pop in that cycle; storage and error flags unchanged.
- REQ-023: top SHALL equal mem[count-1] when not empty and all-zero when empty.
- REQ-024: count SHALL never exceed DEPTH nor wrap below 0; no pointer wrap-around exists.
- REQ-025: Latency: result of an operation SHALL be visible on top/count/flags exactly one cycle after the edge that captures it.
- REQ-026: Flags SHALL be set on the edge capturing the offending request; err_clr clears both on the next edge; a simultaneous error and err_clr SHALL leave the flag set.

Reset
- REQ-027: rst SHALL override clear, push, pop and err_clr.
- REQ-028: After reset: count=0, empty=1, full=0, top=0, ovf=0, unf=0, all storage entries zero.
- REQ-029: Reset asserted mid-sequence SHALL discard all contents in the same edge; first push after release lands in entry 0.

Configuration
- REQ-030: Macro LIFO_ERR_FLAGS_EN SHALL gate the sticky error logic.
- REQ-031: Defined: ovf/unf behave per REQ-017, REQ-019 and REQ-026.
- REQ-032: Undefined: ovf/unf tied to 0, err_clr ignored; illegal push/pop still ignored as in REQ-017/REQ-019.

Structure
- REQ-033: Package lifo_pkg SHALL hold the op enum (OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE) and the default WIDTH/DEPTH constants.
- REQ-034: Storage SHALL be one sub-module lifo_regfile (DEPTH x WIDTH, one write port, one async read port, synchronous reset to zero); pointer and flag logic stay in lifo_stack.

Verification (WIDTH=12, DEPTH=5, macro defined unless noted)
- REQ-035: Push 0x001..0x005 -> full=1, count=5, top=0x005; five pops -> top 0x004,0x003,0x002,0x001, then empty=1, top=0.
- REQ-036: Full, push 0x0AA -> count=5, top=0x005, ovf=1; err_clr -> ovf=0 next cycle.
- REQ-037: Empty, pop -> count=0, unf=1; push&pop with din=0x123 on empty -> count=1, top=0x123.
- REQ-038: Three entries, push&pop with din=0xFFF -> count=3, top=0xFFF, entry below unchanged.
- REQ-039: Four entries, clear with push -> count=0, empty=1; then rst mid-push -> all outputs at reset values.
- REQ-040: Macro undefined, pop on empty and push on full -> ovf=unf=0 throughout, count unchanged.
